// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers, with frame locking.
// Optional stale-lock timeout is compiled in with `define UART_TX_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int LOCK_TO = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       trmt,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0] NUM_W = (PW+1)'(NUM_REQ);

    // Out-of-range parameters stop elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TO < 1) begin : g_param_check
        $error("uart_tx_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 trmt_q, trmt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic [NUM_REQ-1:0]   owner_oh;
    logic [NUM_REQ-1:0]   elig;
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [PW:0]          cand;
    logic                 grant;
    logic                 to_expire;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (x == PW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Search rr_ptr, rr_ptr+1, ... ; iterating from the far end lets the nearest hit win.
    always_comb begin
        owner_oh  = NUM_REQ'(1) << owner_q;
        elig      = lock_q ? (req & owner_oh) : req;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (elig[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    assign grant = (state_q == IDLE) && win_found && tx_done;

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TO) + 1;

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_idle;

    // A locked owner that has gone quiet in IDLE is counted; any grant or owner request clears it.
    assign to_idle   = (state_q == IDLE) && lock_q && !req[owner_q];
    assign to_expire = to_idle && (to_cnt_q == TW'(LOCK_TO - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_idle && !to_expire) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)    state_d = LAUNCH;
            LAUNCH:                state_d = WAIT_LO;
            WAIT_LO: if (!tx_done) state_d = WAIT_HI;
            WAIT_HI: if (tx_done)  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // trmt/ack are registered from the grant, so they are high exactly while in LAUNCH.
    always_comb begin
        trmt_d    = grant;
        ack_d     = grant ? (NUM_REQ'(1) << win_idx) : '0;
        tx_data_d = tx_data_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            tx_data_d = req_data[{win_idx, 3'b000} +: 8];
            owner_d   = win_idx;
            lock_d    = ~req_last[win_idx];
            if (req_last[win_idx]) begin
                rr_ptr_d = wrap_inc(win_idx);
            end
        end else if (to_expire) begin
            lock_d   = 1'b0;
            rr_ptr_d = wrap_inc(owner_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            tx_data_q <= 8'h00;
            trmt_q    <= 1'b0;
            ack_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            ack_q     <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign trmt    = trmt_q;
    assign tx_data = tx_data_q;
    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed client traffic, a simple transmitter model,
// and a monitor that checks every launch against the expected grant queue.
module tb_uart_tx_arb;

    localparam int N      = 4;
    localparam int TX_CYC = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] ack;
    logic         trmt;
    logic [7:0]   tx_data;
    logic         tx_done;
    logic         busy;
    logic [1:0]   owner;

    logic tx_idle  = 1'b1;
    logic tx_stall = 1'b0;
    assign tx_done = tx_idle & ~tx_stall;

    uart_tx_arb #(.NUM_REQ(N), .LOCK_TO(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int launches = 0;

    typedef struct packed {
        logic [1:0] client;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [8:0] cbuf [N][8];
    int         chead [N];
    int         ctail [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void drive_req();
        for (int i = 0; i < N; i++) begin
            if (chead[i] < ctail[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = cbuf[i][chead[i]][7:0];
                req_last[i]       = cbuf[i][chead[i]][8];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endfunction

    task automatic load(input int c, input logic [7:0] d, input logic last);
        cbuf[c][ctail[c]] = {last, d};
        ctail[c]++;
        drive_req();
    endtask

    task automatic expect_grant(input int c, input logic [7:0] d);
        exp_t e;
        e.client = 2'(c);
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_clients();
        for (int i = 0; i < N; i++) begin
            chead[i] = 0;
            ctail[i] = 0;
        end
        drive_req();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(busy == 1'b0 && tx_done == 1'b1 && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout, busy=%b pending=%0d, expected idle with 0 pending",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic wait_launches(input string name, input int target, input int budget);
        int n = 0;
        while (launches < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout, launches=%0d, expected %0d", name, launches, target);
        end
    endtask

    // Clients: a byte is consumed on its ack and the next one (if any) is presented.
    initial begin
        clear_clients();
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && chead[i] < ctail[i]) chead[i]++;
            end
            drive_req();
        end
    end

    // Transmitter: tx_done drops the cycle after trmt and rises TX_CYC cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && trmt) begin
                @(posedge clk);
                #1 tx_idle = 1'b0;
                repeat (TX_CYC) @(posedge clk);
                #1 tx_idle = 1'b1;
            end
        end
    end

    // Monitor: every launch must match the head of the expected-grant queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (trmt || ack != '0)) begin
                launches++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: ack=%b trmt=%b data=0x%0h, expected no grant",
                             ack, trmt, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("grant #%0d: client %0d data 0x%0h (expected client %0d data 0x%0h)",
                             launches, owner, tx_data, e.client, e.data);
                    chk("grant_trmt", 32'(trmt), 32'd1);
                    chk("grant_ack", 32'(ack), 32'(1) << e.client);
                    chk("grant_data", 32'(tx_data), 32'(e.data));
                    chk("grant_owner", 32'(owner), 32'(e.client));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_trmt", 32'(trmt), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin from reset: 0,1,2,3 then 0 again (3 -> 0 wrap).
        expect_grant(0, 8'h10);
        expect_grant(1, 8'h21);
        expect_grant(2, 8'h32);
        expect_grant(3, 8'h43);
        expect_grant(0, 8'h14);
        load(0, 8'h10, 1'b1);
        load(0, 8'h14, 1'b1);
        load(1, 8'h21, 1'b1);
        load(2, 8'h32, 1'b1);
        load(3, 8'h43, 1'b1);
        wait_idle("rr_done", 2000);

        // Single byte from client 2 (rr_ptr=1): launch one cycle after req.
        expect_grant(2, 8'hA5);
        load(2, 8'hA5, 1'b1);
        @(negedge clk);
        chk("lat_trmt", 32'(trmt), 32'd1);
        chk("lat_ack", 32'(ack), 32'b0100);
        chk("lat_tx_data", 32'(tx_data), 32'hA5);
        repeat (20) @(negedge clk);
        chk("mid_tx_busy", 32'(busy), 32'd1);
        wait_idle("single_done", 400);
        chk("tx_data_hold", 32'(tx_data), 32'hA5);

        // Back-pressure: transmitter busy in IDLE; rr_ptr=3 makes client 3 beat client 1.
        expect_grant(3, 8'h3C);
        expect_grant(1, 8'h1B);
        tx_stall = 1'b1;
        load(3, 8'h3C, 1'b1);
        load(1, 8'h1B, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_no_trmt", 32'(trmt), 32'd0);
            chk("stall_no_ack", 32'(ack), 32'd0);
        end
        tx_stall = 1'b0;
        @(negedge clk);
        chk("stall_release_ack", 32'(ack), 32'b1000);
        wait_idle("bp_done", 800);

        // Frame lock: client 1 owns a 3-byte frame; client 0 (nearer rr_ptr=2) waits.
        expect_grant(1, 8'hB1);
        expect_grant(1, 8'hB2);
        expect_grant(1, 8'hB3);
        expect_grant(0, 8'h0F);
        load(1, 8'hB1, 1'b0);
        load(1, 8'hB2, 1'b0);
        load(1, 8'hB3, 1'b1);
        wait_launches("lock_first", launches + 1, 200);
        load(0, 8'h0F, 1'b1);
        wait_idle("lock_done", 1500);

        // Reset mid-frame in WAIT_HI with the lock held by client 2.
        expect_grant(2, 8'hC2);
        load(2, 8'hC2, 1'b0);
        wait_launches("rst_first", launches + 1, 200);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        clear_clients();
        @(negedge clk);
        chk("midrst_trmt", 32'(trmt), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        expect_grant(0, 8'h5A);
        expect_grant(2, 8'h2A);
        load(0, 8'h5A, 1'b1);
        load(2, 8'h2A, 1'b1);
        wait_idle("post_rst_done", 800);

        repeat (5) @(negedge clk);
        chk("launch_count", 32'(launches), 32'd15);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
